// File: rtl/dlsc_pcie_pktgen.sv
// Packet stream generator: accepts (len, seed) commands and emits len+1 pattern words with last on the final word.
// Latency: word 0 is presented the cycle after command acceptance; one word per cycle at full rate; one idle bubble between packets.
// Backpressure: ready low holds data/last stable with valid high; cmd_ready is low while a packet is being sent.
// Optional feature: define DLSC_PCIE_PKTGEN_LFSR_EN for a 32-bit Galois LFSR pattern instead of the incrementing pattern.
module dlsc_pcie_pktgen #(
  parameter int LENB = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            cmd_ready,
  input  logic            cmd_valid,
  input  logic [LENB-1:0] cmd_len,
  input  logic [31:0]     cmd_seed,
  output logic            valid,
  input  logic            ready,
  output logic [31:0]     data,
  output logic            last,
  output logic            pkt_done,
  output logic [15:0]     pkt_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [LENB-1:0] len_r;
  logic [LENB-1:0] idx;
  logic            accept;
  logic            xfer;
  logic            xfer_last;
  logic [31:0]     seed_word;
  logic [31:0]     next_word;

`ifdef DLSC_PCIE_PKTGEN_LFSR_EN
  // An all-zero seed would lock the LFSR at zero, so it is forced to 1.
  assign seed_word = (cmd_seed == 32'd0) ? 32'd1 : cmd_seed;
  assign next_word = {1'b0, data[31:1]} ^ (data[0] ? 32'h80200003 : 32'h00000000);
`else
  assign seed_word = cmd_seed;
  assign next_word = data + 32'd1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs; valid/last come straight from registered state.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    xfer_last = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        accept    = cmd_valid;
        if (cmd_valid) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        valid     = 1'b1;
        last      = (idx == len_r);
        xfer      = ready;
        xfer_last = ready && (idx == len_r);
        if (xfer_last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch command, advance pattern and index per transfer, count completed packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= 32'd0;
      len_r     <= '0;
      idx       <= '0;
      pkt_done  <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      pkt_done <= xfer_last;
      if (accept) begin
        len_r <= cmd_len;
        data  <= seed_word;
        idx   <= '0;
      end else if (xfer) begin
        data <= next_word;
        idx  <= idx + 1'b1;
      end
      if (xfer_last) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule
